alu_bus_master: RTL and testbench

Bus initiator for the Argon ALU peripheral. It accepts one operation request (op, A, B, optional flag preload) on a valid/ready port and drives the shared `bus_if` command sequence to latch operands and opcode into the ALU. It then reads back result Y and the flags word and returns both on a held response port. It sits between the core sequencer and the ALU's `bus_if` and is the only agent driving that bus.

---
 rtl/alu_bus_master.sv | 176 +++++++++++++++++
 tb/tb_alu_bus_master.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_bus_master.sv
// Bus initiator for the Argon ALU: latches flags/operands/opcode over the
// shared command bus, reads back Y and flags, and holds them on a response port.

package alu_bus_master_pkg;
   localparam int WORDSIZE = 16;
   typedef logic [WORDSIZE-1:0] word_t;

   // com_none decodes to no ALU action; the bus idles on it
   typedef enum logic [2:0] {
      com_none    = 3'd0,
      com_latchF  = 3'd1,
      com_latchA  = 3'd2,
      com_latchB  = 3'd3,
      com_latchOp = 3'd4,
      com_outputY = 3'd5,
      com_outputF = 3'd6
   } command_t;

   localparam logic [3:0] ALU_ADD = 4'h0;
   localparam logic [3:0] ALU_ADC = 4'h1;
   localparam logic [3:0] ALU_SUB = 4'h2;
   localparam logic [3:0] ALU_SBC = 4'h3;
   localparam logic [3:0] ALU_AND = 4'h4;
   localparam logic [3:0] ALU_OR  = 4'h5;
   localparam logic [3:0] ALU_XOR = 4'h6;
   localparam logic [3:0] ALU_CMP = 4'h7;

   localparam int F_CARRY   = 0;
   localparam int F_ZERO    = 1;
   localparam int F_GREATER = 2;
   localparam int F_EQUAL   = 3;
   localparam int F_LESS    = 4;
endpackage

// Handshakes: a request transfers on the rising edge where req_valid & req_ready
// (req_ready only in IDLE); a response transfers where rsp_valid & rsp_ready
// (rsp_valid only in RESP). Either side may hold valid/ready without side effects.
module alu_bus_master
   import alu_bus_master_pkg::*;
(
   input  logic        i_Clk,
   input  logic        i_Reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  req_op,
   input  word_t       req_a,
   input  word_t       req_b,
   input  logic        req_flags_load,
   input  word_t       req_flags,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output word_t       rsp_result,
   output word_t       rsp_flags,
   output logic        rsp_err,
   output word_t       txn_count,
   output command_t    bus_command,
   output logic        bus_i_valid,
   output word_t       bus_i_data,
   input  word_t       bus_o_data,
   input  logic        bus_o_valid,
   output logic [2:0]  dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_LATCH_F  = 3'd1,
      S_LATCH_A  = 3'd2,
      S_LATCH_B  = 3'd3,
      S_LATCH_OP = 3'd4,
      S_READ_Y   = 3'd5,
      S_READ_F   = 3'd6,
      S_RESP     = 3'd7
   } state_t;

   state_t     r_state, w_state_next;
   logic       w_accept;
   logic [3:0] r_op;
   word_t      r_a, r_b, r_flags_in;
   word_t      r_result, r_flags, r_txn;
   logic       r_err;
   command_t   r_command, w_command;
   logic       r_i_valid, w_i_valid;
   word_t      r_i_data, w_i_data;
   word_t      w_a_src, w_flags_src;

   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (req_valid) begin
               w_accept     = 1'b1;
               w_state_next = req_flags_load ? S_LATCH_F : S_LATCH_A;
            end
         end
         S_LATCH_F:  w_state_next = S_LATCH_A;
         S_LATCH_A:  w_state_next = S_LATCH_B;
         S_LATCH_B:  w_state_next = S_LATCH_OP;
         S_LATCH_OP: w_state_next = S_READ_Y;
         S_READ_Y:   w_state_next = S_READ_F;
         S_READ_F:   w_state_next = S_RESP;
         S_RESP:     if (rsp_ready) w_state_next = S_IDLE;
         default:    w_state_next = S_IDLE;
      endcase
   end

   // Bus drive is computed from the next state so the registered bus lines
   // line up with r_state; on the acceptance edge the data comes from req_*.
   assign w_a_src     = w_accept ? req_a : r_a;
   assign w_flags_src = w_accept ? req_flags : r_flags_in;

   always_comb begin
      w_command = com_none;
      w_i_valid = 1'b0;
      w_i_data  = '0;
      case (w_state_next)
         S_LATCH_F:  begin w_command = com_latchF;  w_i_valid = 1'b1; w_i_data = w_flags_src; end
         S_LATCH_A:  begin w_command = com_latchA;  w_i_valid = 1'b1; w_i_data = w_a_src; end
         S_LATCH_B:  begin w_command = com_latchB;  w_i_valid = 1'b1; w_i_data = r_b; end
         S_LATCH_OP: begin w_command = com_latchOp; w_i_valid = 1'b1; w_i_data = {12'h000, r_op}; end
         S_READ_Y:   w_command = com_outputY;
         S_READ_F:   w_command = com_outputF;
         default:    w_command = com_none;
      endcase
   end

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         r_state    <= S_IDLE;
         r_op       <= '0;
         r_a        <= '0;
         r_b        <= '0;
         r_flags_in <= '0;
         r_result   <= '0;
         r_flags    <= '0;
         r_err      <= 1'b0;
         r_txn      <= '0;
         r_command  <= com_none;
         r_i_valid  <= 1'b0;
         r_i_data   <= '0;
      end else begin
         r_state   <= w_state_next;
         r_command <= w_command;
         r_i_valid <= w_i_valid;
         r_i_data  <= w_i_data;
         if (w_accept) begin
            r_op       <= req_op;
            r_a        <= req_a;
            r_b        <= req_b;
            r_flags_in <= req_flags;
            r_err      <= 1'b0;
         end
         if (r_state == S_READ_Y) begin
            r_result <= bus_o_data;
            if (!bus_o_valid) r_err <= 1'b1;
         end
         if (r_state == S_READ_F) begin
            r_flags <= bus_o_data;
            if (!bus_o_valid) r_err <= 1'b1;
         end
         if (r_state == S_RESP && rsp_ready) r_txn <= r_txn + 16'd1;
      end
   end

   assign req_ready   = (r_state == S_IDLE);
   assign rsp_valid   = (r_state == S_RESP);
   assign rsp_result  = r_result;
   assign rsp_flags   = r_flags;
   assign rsp_err     = r_err;
   assign txn_count   = r_txn;
   assign bus_command = r_command;
   assign bus_i_valid = r_i_valid;
   assign bus_i_data  = r_i_data;
   assign dbg_state   = r_state;

endmodule

// File: tb/tb_alu_bus_master.sv
// Directed bench for alu_bus_master with a behavioural Argon ALU on the bus
// and an expected-response queue checked when each response appears.
module tb_alu_bus_master;
  import alu_bus_master_pkg::*;

  logic        i_Clk = 1'b0;
  logic        i_Reset;
  logic        req_valid, req_ready;
  logic [3:0]  req_op;
  logic [15:0] req_a, req_b, req_flags;
  logic        req_flags_load;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_result, rsp_flags, txn_count;
  logic        rsp_err;
  command_t    bus_command;
  logic        bus_i_valid;
  logic [15:0] bus_i_data, bus_o_data;
  logic        bus_o_valid;
  logic [2:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_txn;
  logic [32:0] exp_q[$];
  logic        kill_ovalid;

  // clock / reset block
  always #5 i_Clk = ~i_Clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1);
  end

  alu_bus_master dut (
    .i_Clk(i_Clk), .i_Reset(i_Reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_flags_load(req_flags_load), .req_flags(req_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .rsp_err(rsp_err), .txn_count(txn_count),
    .bus_command(bus_command), .bus_i_valid(bus_i_valid), .bus_i_data(bus_i_data),
    .bus_o_data(bus_o_data), .bus_o_valid(bus_o_valid), .dbg_state(dbg_state)
  );

  // behavioural ALU on the far side of the bus
  logic [15:0] m_a, m_b, m_flags;
  logic [3:0]  m_op;
  logic [31:0] m_eval;

  function automatic logic [31:0] alu_eval(input logic [3:0] op, input logic [15:0] a,
                                           input logic [15:0] b, input logic [15:0] f);
    logic [16:0] s;
    logic [15:0] y, nf;
    nf = '0;
    y  = '0;
    s  = '0;
    case (op)
      ALU_ADD: begin
        s = {1'b0, a} + {1'b0, b};
        y = s[15:0]; nf[F_CARRY] = s[16]; nf[F_ZERO] = (y == 16'h0);
      end
      ALU_ADC: begin
        s = {1'b0, a} + {1'b0, b} + {16'h0, f[F_CARRY]};
        y = s[15:0]; nf[F_CARRY] = s[16]; nf[F_ZERO] = (y == 16'h0);
      end
      ALU_CMP: begin
        nf[F_GREATER] = (a > b); nf[F_EQUAL] = (a == b); nf[F_LESS] = (a < b);
      end
      default: y = a;
    endcase
    return {y, nf};
  endfunction

  assign m_eval = alu_eval(m_op, m_a, m_b, m_flags);

  always @(posedge i_Clk) begin
    if (bus_i_valid) begin
      case (bus_command)
        com_latchF:  m_flags <= bus_i_data;
        com_latchA:  m_a     <= bus_i_data;
        com_latchB:  m_b     <= bus_i_data;
        com_latchOp: m_op    <= bus_i_data[3:0];
        default: ;
      endcase
    end else if (bus_command == com_outputY) begin
      m_flags <= m_eval[15:0];
    end
  end

  assign bus_o_data  = (bus_command == com_outputY) ? m_eval[31:16] :
                       (bus_command == com_outputF) ? m_flags : 16'h0;
  assign bus_o_valid = ((bus_command == com_outputY) || (bus_command == com_outputF)) && !kill_ovalid;

  // scoreboard comparison point
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask

  // driver: one full transaction with optional backpressure and o_valid kill in READ_F
  task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic fl_load, input logic [15:0] fl, input logic kill_f,
                        input int hold, input logic [15:0] e_res, input logic [15:0] e_flg,
                        input logic e_err);
    int cyc;
    int k;
    logic [32:0] exp;
    command_t e_cmd;
    logic [15:0] e_dat;
    cyc = 0;
    while (!req_ready && cyc < 20) begin tick(); cyc++; end
    check("req_ready_idle", {31'h0, req_ready}, 32'h1);
    req_op = op; req_a = a; req_b = b; req_flags_load = fl_load; req_flags = fl;
    req_valid = 1'b1;
    exp_q.push_back({e_err, e_res, e_flg});
    tick();
    req_valid = 1'b0;
    req_a = 16'($urandom); req_b = 16'($urandom); req_flags = 16'($urandom);
    req_op = 4'($urandom_range(0, 15)); req_flags_load = 1'($urandom_range(0, 1));
    k   = fl_load ? 0 : 1;
    cyc = 1;
    while (!rsp_valid && cyc < 20) begin
      e_dat = 16'h0;
      case (k)
        0: begin e_cmd = com_latchF;  e_dat = fl; end
        1: begin e_cmd = com_latchA;  e_dat = a; end
        2: begin e_cmd = com_latchB;  e_dat = b; end
        3: begin e_cmd = com_latchOp; e_dat = {12'h000, op}; end
        4: e_cmd = com_outputY;
        5: e_cmd = com_outputF;
        default: e_cmd = com_none;
      endcase
      check("bus_cmd", {29'h0, bus_command}, {29'h0, e_cmd});
      check("bus_i_valid", {31'h0, bus_i_valid}, {31'h0, (k < 4)});
      if (k < 4) check("bus_i_data", {16'h0, bus_i_data}, {16'h0, e_dat});
      kill_ovalid = kill_f && (k == 5);
      tick();
      cyc++;
      k++;
    end
    kill_ovalid = 1'b0;
    check("latency", cyc, fl_load ? 32'd7 : 32'd6);
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 32'h1, {31'h0, rsp_valid} + 32'h1);
      exp = '0;
    end else begin
      exp = exp_q.pop_front();
    end
    check("rsp_result", {16'h0, rsp_result}, {16'h0, exp[31:16]});
    check("rsp_flags", {16'h0, rsp_flags}, {16'h0, exp[15:0]});
    check("rsp_err", {31'h0, rsp_err}, {31'h0, exp[32]});
    check("resp_bus_none", {29'h0, bus_command, bus_i_valid}, 32'h0);
    check("resp_bus_data", {16'h0, bus_i_data}, 32'h0);
    for (int h = 0; h < hold; h++) begin
      tick();
      check("hold_valid", {30'h0, rsp_valid, req_ready}, 32'h2);
      check("hold_result", {rsp_flags, rsp_result}, {exp[15:0], exp[31:16]});
      check("hold_bus", {29'h0, bus_command}, {29'h0, com_none});
      check("hold_txn", {16'h0, txn_count}, {16'h0, exp_txn});
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    exp_txn = exp_txn + 16'd1;
    check("post_resp_ready", {30'h0, req_ready, rsp_valid}, 32'h2);
    check("txn_count", {16'h0, txn_count}, {16'h0, exp_txn});
    check("post_resp_result", {16'h0, rsp_result}, {16'h0, exp[31:16]});
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready_valid"}, {30'h0, req_ready, rsp_valid}, 32'h2);
    check({tag, "_result"}, {rsp_flags, rsp_result}, 32'h0);
    check({tag, "_err_txn"}, {15'h0, rsp_err, txn_count}, 32'h0);
    check({tag, "_bus"}, {12'h0, bus_command, bus_i_valid, bus_i_data}, 32'h0);
    check({tag, "_state"}, {29'h0, dbg_state}, 32'h0);
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic [16:0] rs;
    logic        saw_valid;
    i_Reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; kill_ovalid = 1'b0;
    req_op = '0; req_a = '0; req_b = '0; req_flags = '0; req_flags_load = 1'b0;
    exp_txn = '0;
    tick(); tick();
    i_Reset = 1'b0;
    check_reset_values("reset");

    run_op(ALU_ADD, 16'h0003, 16'h0004, 1'b0, 16'h0000, 1'b0, 0, 16'h0007, 16'h0000, 1'b0);
    run_op(ALU_ADD, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b0, 0, 16'h0000, 16'h0003, 1'b0);
    run_op(ALU_ADC, 16'h0001, 16'h0001, 1'b1, 16'h0001, 1'b0, 0, 16'h0003, 16'h0000, 1'b0);
    run_op(ALU_ADC, 16'h0001, 16'h0001, 1'b1, 16'h0000, 1'b0, 0, 16'h0002, 16'h0000, 1'b0);
    run_op(ALU_CMP, 16'h0005, 16'h0003, 1'b0, 16'h0000, 1'b0, 0, 16'h0000, 16'h0004, 1'b0);
    run_op(ALU_ADD, 16'h1234, 16'h1111, 1'b0, 16'h0000, 1'b0, 5, 16'h2345, 16'h0000, 1'b0);

    // reset while in LATCH_B abandons the transaction
    req_op = ALU_ADD; req_a = 16'h00AA; req_b = 16'h0055; req_flags_load = 1'b0;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    check("mid_latchB", {29'h0, bus_command}, {29'h0, com_latchB});
    i_Reset = 1'b1;
    tick();
    i_Reset = 1'b0;
    exp_txn = '0;
    check_reset_values("mid_reset");
    saw_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      saw_valid = saw_valid | rsp_valid;
    end
    check("no_rsp_after_reset", {31'h0, saw_valid}, 32'h0);

    run_op(ALU_ADD, 16'h0002, 16'h0002, 1'b0, 16'h0000, 1'b1, 0, 16'h0004, 16'h0000, 1'b1);
    run_op(ALU_ADD, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b0, 2, 16'h0000, 16'h0003, 1'b0);

    for (int i = 0; i < 3; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = {1'b0, ra} + {1'b0, rb};
      run_op(ALU_ADD, ra, rb, 1'b0, 16'h0000, 1'b0, $urandom_range(0, 3), rs[15:0],
             {14'h0, (rs[15:0] == 16'h0), rs[16]}, 1'b0);
    end

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
